fadd_result_collector: RTL and testbench

- Consumer-side companion to the 4-stage single-precision pipelined adder.
- Tracks each issued add/sub through the adder's fixed-latency, non-stallable pipeline using a tag shift register.
- Captures each result at its exact arrival cycle into a FWFT FIFO and presents it downstream on a valid/ready stream with tag and IEEE-754 class flags.
- A credit counter throttles issue so a result never arrives while the FIFO is full.

---
 rtl/fadd_result_collector.sv | 119 +++++++++++
 tb/tb_fadd_result_collector.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fadd_result_collector.sv
// Result collector for a fixed-latency, non-stallable FP adder: tracks tags through the
// adder latency, captures results into a FWFT FIFO and throttles issue with credits.
module fadd_result_collector #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [TAG_W-1:0]         s_tag,
  output logic                     fadd_fire,
  input  logic [31:0]              fadd_result,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [31:0]              m_result,
  output logic [TAG_W-1:0]         m_tag,
  output logic [3:0]               m_flags,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_overflow
);
  localparam int          AW      = $clog2(DEPTH);
  localparam int          EW      = 32 + TAG_W + 4;
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] CREDITS = (AW+1)'(DEPTH);

  // {nan, inf, zero, sign}; denormals fall through with only the sign bit.
  function automatic logic [3:0] fp_class(input logic [31:0] r);
    logic exp_max, exp_zero, mant_zero;
    exp_max   = &r[30:23];
    exp_zero  = ~|r[30:23];
    mant_zero = ~|r[22:0];
    return {exp_max & ~mant_zero, exp_max & mant_zero, exp_zero & mant_zero, r[31]};
  endfunction

  logic [LATENCY-1:0]       vld_q, vld_nxt;
  logic [LATENCY*TAG_W-1:0] tag_q, tag_nxt;
  logic [EW-1:0]            mem_q [DEPTH];
  logic [AW:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, out_q, out_d;
  logic                     ovf_q, ovf_d;
  logic [EW-1:0]            last_q, last_d, head, disp;
  logic                     empty, full, cap, pop, wr_en;
  logic [TAG_W-1:0]         cap_tag;

  assign s_ready   = out_q < CREDITS;
  assign fadd_fire = s_valid & s_ready;

  if (LATENCY == 1) begin : g_lat1
    assign vld_nxt = fadd_fire;
    assign tag_nxt = s_tag;
  end else begin : g_latn
    assign vld_nxt = {vld_q[LATENCY-2:0], fadd_fire};
    assign tag_nxt = {tag_q[(LATENCY-1)*TAG_W-1:0], s_tag};
  end

  assign cap     = vld_q[LATENCY-1];
  assign cap_tag = tag_q[LATENCY*TAG_W-1 -: TAG_W];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign pop   = m_valid & m_ready;
  // A full FIFO may still take a capture when its head leaves on the same edge.
  assign wr_en = cap & (~full | pop);

  // When empty the outputs keep showing the most recently popped entry.
  assign disp         = empty ? last_q : head;
  assign m_valid      = ~empty;
  assign m_result     = disp[EW-1 -: 32];
  assign m_tag        = disp[TAG_W+3:4];
  assign m_flags      = disp[3:0];
  assign outstanding  = out_q;
  assign err_overflow = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    out_d    = out_q;
    last_d   = last_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + ONE;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ONE;
      last_d   = head;
    end
    if (cap & full & ~pop) ovf_d = 1'b1;
    case ({fadd_fire, pop})
      2'b10:   out_d = out_q + ONE;
      2'b01:   if (out_q != '0) out_d = out_q - ONE;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q    <= '0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      vld_q    <= vld_nxt;
      tag_q    <= tag_nxt;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {fadd_result, cap_tag, fp_class(fadd_result)};
  end

endmodule

// File: tb/tb_fadd_result_collector.sv
// Bench for fadd_result_collector: plays the fixed-latency adder and keeps an
// issue-order scoreboard of expected results, tags and class flags.
module tb_fadd_result_collector;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int TW    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, fadd_fire, m_valid, m_ready, err_overflow;
  logic [TW-1:0] s_tag, m_tag;
  logic [31:0] fadd_result, m_result;
  logic [3:0]  m_flags;
  logic [3:0]  outstanding;

  fadd_result_collector #(.LATENCY(LAT), .DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_tag(s_tag),
    .fadd_fire(fadd_fire), .fadd_result(fadd_result), .m_valid(m_valid),
    .m_ready(m_ready), .m_result(m_result), .m_tag(m_tag), .m_flags(m_flags),
    .outstanding(outstanding), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   r;
    logic [TW-1:0] t;
    int            due;
  } op_t;

  op_t exp_q[$];
  op_t pend_q[$];
  int  cyc = 0, n_cmp = 0, n_bad = 0, fires = 0, pops = 0;

  // Class by magnitude ordering of the IEEE-754 bit pattern.
  function automatic logic [3:0] cls(input logic [31:0] r);
    logic [30:0] mag;
    mag = r[30:0];
    return {mag > 31'h7F800000, mag == 31'h7F800000, mag == 31'd0, r[31]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check against the model, advance the model.
  task automatic step(input bit sv, input logic [TW-1:0] tg, input logic [31:0] res, input bit mr);
    op_t o;
    bit  exp_mv, can_fire;
    s_valid = sv;
    s_tag   = tg;
    m_ready = mr;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      o = pend_q.pop_front();
      fadd_result = o.r;
    end else begin
      fadd_result = $urandom;
    end
    #1;
    exp_mv   = exp_q.size() > 0 && exp_q[0].due < cyc;
    can_fire = exp_q.size() < DEPTH;
    chk("s_ready", s_ready, can_fire);
    chk("outstanding", outstanding, exp_q.size());
    chk("m_valid", m_valid, exp_mv);
    chk("fadd_fire", fadd_fire, sv && can_fire);
    chk("err_overflow", err_overflow, 1'b0);
    if (exp_mv && mr) begin
      o = exp_q.pop_front();
      chk("m_result", m_result, o.r);
      chk("m_tag", m_tag, o.t);
      chk("m_flags", m_flags, cls(o.r));
      pops++;
    end
    if (sv && can_fire) begin
      o.r = res; o.t = tg; o.due = cyc + LAT;
      exp_q.push_back(o);
      pend_q.push_back(o);
      fires++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      step(1'b0, '0, 32'd0, 1'b1);
      n++;
    end
    chk("drain_outstanding", outstanding, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, pbase, n, issued, g;
    logic [31:0] r;

    // Reset state
    rst = 1'b0; s_valid = 1'b0; s_tag = '0; m_ready = 1'b0; fadd_result = 32'h0;
    #2;
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_result", m_result, 32'h0);
    chk("rst_m_tag", m_tag, 4'h0);
    chk("rst_m_flags", m_flags, 4'h0);
    chk("rst_fadd_fire", fadd_fire, 1'b0);
    chk("rst_outstanding", outstanding, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Sign-of-zero subtraction: 0 - (-0) = +0
    step(1'b1, 4'd3, 32'h00000000, 1'b1);
    n = 0;
    while (!m_valid && n < 10) begin
      step(1'b0, '0, 32'd0, 1'b1);
      n++;
    end
    chk("zero_latency", n, LAT);
    chk("zero_result", m_result, 32'h00000000);
    chk("zero_tag", m_tag, 4'd3);
    chk("zero_flags", m_flags, 4'b0010);
    drain(20);

    // Ordered back-to-back results
    step(1'b1, 4'd0, 32'h41BF3E2D, 1'b1);
    step(1'b1, 4'd1, 32'h40594155, 1'b1);
    step(1'b1, 4'd2, 32'hC0594155, 1'b1);
    step(1'b1, 4'd3, 32'hC1BF3E2D, 1'b1);
    drain(20);

    // Special classes
    step(1'b1, 4'd5, 32'h7F800000, 1'b0);
    step(1'b1, 4'd6, 32'h7FC00000, 1'b0);
    step(1'b1, 4'd7, 32'h80000000, 1'b0);
    repeat (LAT) step(1'b0, '0, 32'd0, 1'b0);
    chk("inf_flags", m_flags, 4'b0100);
    step(1'b0, '0, 32'd0, 1'b1);
    chk("nan_flags", m_flags, 4'b1000);
    step(1'b0, '0, 32'd0, 1'b1);
    chk("negzero_flags", m_flags, 4'b0011);
    drain(20);

    // Credit back-pressure
    base = fires;
    for (int i = 0; i < 12; i++) step(1'b1, 4'(i), $urandom, 1'b0);
    chk("credit_fires", fires - base, 8);
    chk("credit_s_ready", s_ready, 1'b0);
    chk("credit_outstanding", outstanding, 8);
    base = fires;
    step(1'b1, 4'd9, $urandom, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 4'd10, $urandom, 1'b0);
    chk("credit_refire", fires - base, 1);
    chk("credit_overflow", err_overflow, 1'b0);
    drain(40);

    // Reset mid-flight
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 4), $urandom, 1'b0);
    step(1'b0, '0, 32'd0, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_m_valid", m_valid, 1'b0);
    chk("midrst_outstanding", outstanding, 0);
    chk("midrst_s_ready", s_ready, 1'b1);
    exp_q.delete();
    pend_q.delete();
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, '0, 32'd0, 1'b1);
    chk("midrst_after", m_valid, 1'b0);

    // Wrap-around with random back-pressure
    base = fires; pbase = pops; g = 0; issued = 0;
    while (issued < 20 && g < 400) begin
      case ($urandom_range(0, 4))
        0:       r = 32'h7F800000 | ($urandom & 32'h80000000);
        1:       r = $urandom & 32'h807FFFFF;
        default: r = $urandom;
      endcase
      step($urandom_range(0, 3) != 0, 4'(issued), r, $urandom_range(0, 1) == 1);
      issued = fires - base;
      g++;
    end
    g = 0;
    while (exp_q.size() > 0 && g < 400) begin
      step(1'b0, '0, 32'd0, $urandom_range(0, 1) == 1);
      g++;
    end
    chk("wrap_delivered", pops - pbase, 20);
    chk("wrap_outstanding", outstanding, 0);
    chk("final_overflow", err_overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
